// File: rtl/dcache_arb_pkg.sv
// rtl/dcache_arb_pkg.sv - shared types and constants for the dcache data-array controller
package dcache_arb_pkg;

    localparam int DCACHE_ADDR_WIDTH = 4;
    localparam int LINE_WIDTH        = 256;
    localparam int WMASK_WIDTH       = LINE_WIDTH / 8;

    typedef enum logic {
        INIT = 1'b0,
        IDLE = 1'b1
    } state_e;

    typedef enum logic [2:0] {
        SRC_NONE = 3'd0,
        SRC_FILL = 3'd1,
        SRC_EV   = 3'd2,
        SRC_ST   = 3'd3,
        SRC_LD   = 3'd4
    } src_e;

endpackage

// File: rtl/dcache_arb_prio_sel.sv
// rtl/dcache_arb_prio_sel.sv - combinational requester pick for the data-array port
//
// Picks at most one requester per cycle: fill > evict > store > load.
// Reads (evict/load) to the address written in the previous cycle are held off one cycle.
// A starved load (ld_starved) outranks evict and store, never fill.
// Ports:
//   idle                 controller is in IDLE (no grants otherwise)
//   *_valid              requester valids
//   ev_addr, ld_addr     read addresses checked against the previous write
//   wr_last_valid/addr   write granted in the previous cycle
//   ld_starved           load age override
//   src                  selected source
module dcache_arb_prio_sel
    import dcache_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = DCACHE_ADDR_WIDTH
) (
    input  logic                  idle,
    input  logic                  fill_valid,
    input  logic                  ev_valid,
    input  logic                  st_valid,
    input  logic                  ld_valid,
    input  logic [ADDR_WIDTH-1:0] ev_addr,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic                  wr_last_valid,
    input  logic [ADDR_WIDTH-1:0] wr_last_addr,
    input  logic                  ld_starved,
    output src_e                  src
);

    logic ev_ok;
    logic ld_ok;

    always_comb begin
        ev_ok = ev_valid && !(wr_last_valid && (ev_addr == wr_last_addr));
        ld_ok = ld_valid && !(wr_last_valid && (ld_addr == wr_last_addr));
        src   = SRC_NONE;
        if (!idle) begin
            src = SRC_NONE;
        end else if (fill_valid) begin
            src = SRC_FILL;
        end else if (ld_ok && ld_starved) begin
            src = SRC_LD;
        end else if (ev_ok) begin
            src = SRC_EV;
        end else if (st_valid) begin
            src = SRC_ST;
        end else if (ld_ok) begin
            src = SRC_LD;
        end
    end

endmodule

// File: rtl/dcache_data_array_ctrl.sv
// rtl/dcache_data_array_ctrl.sv - arbiter/sequencer for the single-port dcache data-array SRAM
//
// Arbitrates fill, evict read, masked store and load onto one registered-input SRAM port and
// clears every line after reset or on init_start. Optional load aging: DCACHE_ARB_AGE_EN.
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   init_start / init_busy            request / status of the clear-all sweep
//   fill_*                            full-line write request
//   ev_* / ev_rvalid, ev_rdata        evict read request and response
//   st_*                              masked store request
//   ld_* / ld_rvalid, ld_rdata, ld_rtag  load request and tagged response
//   sram_*                            SRAM macro port (active-low csb/web), sram_dout read data
module dcache_data_array_ctrl
    import dcache_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = DCACHE_ADDR_WIDTH,
    parameter int DATA_WIDTH   = LINE_WIDTH,
    parameter int NUM_WMASKS   = WMASK_WIDTH,
    parameter int TAG_WIDTH    = 3,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  init_start,
    output logic                  init_busy,
    input  logic                  fill_valid,
    output logic                  fill_ready,
    input  logic [ADDR_WIDTH-1:0] fill_addr,
    input  logic [DATA_WIDTH-1:0] fill_data,
    input  logic                  ev_valid,
    output logic                  ev_ready,
    input  logic [ADDR_WIDTH-1:0] ev_addr,
    output logic                  ev_rvalid,
    output logic [DATA_WIDTH-1:0] ev_rdata,
    input  logic                  st_valid,
    output logic                  st_ready,
    input  logic [ADDR_WIDTH-1:0] st_addr,
    input  logic [NUM_WMASKS-1:0] st_wmask,
    input  logic [DATA_WIDTH-1:0] st_data,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [TAG_WIDTH-1:0]  ld_tag,
    output logic                  ld_rvalid,
    output logic [DATA_WIDTH-1:0] ld_rdata,
    output logic [TAG_WIDTH-1:0]  ld_rtag,
    output logic                  sram_csb,
    output logic                  sram_web,
    output logic [NUM_WMASKS-1:0] sram_wmask,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_din,
    input  logic [DATA_WIDTH-1:0] sram_dout
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

    state_e                  state;
    logic [ADDR_WIDTH-1:0]   init_cnt;
    src_e                    src;
    logic                    wr_last_valid;
    logic [ADDR_WIDTH-1:0]   wr_last_addr;
    logic                    ld_starved;

    dcache_arb_prio_sel #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_prio_sel (
        .idle          (state == IDLE),
        .fill_valid    (fill_valid),
        .ev_valid      (ev_valid),
        .st_valid      (st_valid),
        .ld_valid      (ld_valid),
        .ev_addr       (ev_addr),
        .ld_addr       (ld_addr),
        .wr_last_valid (wr_last_valid),
        .wr_last_addr  (wr_last_addr),
        .ld_starved    (ld_starved),
        .src           (src)
    );

    assign fill_ready = (src == SRC_FILL);
    assign ev_ready   = (src == SRC_EV);
    assign st_ready   = (src == SRC_ST);
    assign ld_ready   = (src == SRC_LD);
    assign init_busy  = (state == INIT);

    // Read data is not captured: it is only meaningful in the cycle the matching rvalid is high.
    assign ld_rdata   = sram_dout;
    assign ev_rdata   = sram_dout;

    // The sweep drive is gated by rst so the port is quiet while reset is held.
    always_comb begin
        sram_csb   = 1'b1;
        sram_web   = 1'b1;
        sram_wmask = '0;
        sram_addr  = '0;
        sram_din   = '0;
        if ((state == INIT) && !rst) begin
            sram_csb   = 1'b0;
            sram_web   = 1'b0;
            sram_wmask = '1;
            sram_addr  = init_cnt;
        end else begin
            unique case (src)
                SRC_FILL: begin
                    sram_csb   = 1'b0;
                    sram_web   = 1'b0;
                    sram_wmask = '1;
                    sram_addr  = fill_addr;
                    sram_din   = fill_data;
                end
                SRC_ST: begin
                    sram_csb   = 1'b0;
                    sram_web   = 1'b0;
                    sram_wmask = st_wmask;
                    sram_addr  = st_addr;
                    sram_din   = st_data;
                end
                SRC_EV: begin
                    sram_csb   = 1'b0;
                    sram_addr  = ev_addr;
                end
                SRC_LD: begin
                    sram_csb   = 1'b0;
                    sram_addr  = ld_addr;
                end
                default: begin
                    sram_csb   = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= INIT;
            init_cnt      <= '0;
            ld_rvalid     <= 1'b0;
            ev_rvalid     <= 1'b0;
            ld_rtag       <= '0;
            wr_last_valid <= 1'b0;
            wr_last_addr  <= '0;
        end else begin
            unique case (state)
                INIT: begin
                    if (init_cnt == LAST_ADDR) begin
                        state    <= IDLE;
                        init_cnt <= '0;
                    end else begin
                        init_cnt <= init_cnt + 1'b1;
                    end
                end
                IDLE: begin
                    // A request seen alongside init_start is still granted this cycle.
                    if (init_start) begin
                        state    <= INIT;
                        init_cnt <= '0;
                    end
                end
                default: begin
                    state <= INIT;
                end
            endcase

            ld_rvalid <= (src == SRC_LD);
            ev_rvalid <= (src == SRC_EV);
            if (src == SRC_LD) begin
                ld_rtag <= ld_tag;
            end

            // Remember the last granted write so a same-address read waits one cycle.
            wr_last_valid <= (src == SRC_FILL) || (src == SRC_ST);
            wr_last_addr  <= (src == SRC_FILL) ? fill_addr : st_addr;
        end
    end

`ifdef DCACHE_ARB_AGE_EN
    localparam int AGE_W = $clog2(STARVE_LIMIT + 1);

    logic [AGE_W-1:0] starve_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (src == SRC_LD) begin
            starve_cnt <= '0;
        end else if (ld_valid && !ld_ready && (starve_cnt != AGE_W'(STARVE_LIMIT))) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    assign ld_starved = (starve_cnt >= AGE_W'(STARVE_LIMIT));
`else
    logic unused_starve_limit;

    assign unused_starve_limit = (STARVE_LIMIT != 0);
    assign ld_starved          = 1'b0;
`endif

endmodule

// File: tb/tb_dcache_data_array_ctrl.sv
// tb/tb_dcache_data_array_ctrl.sv - directed self-checking bench for dcache_data_array_ctrl
module tb_dcache_data_array_ctrl;

    localparam int AW = 4;
    localparam int DW = 256;
    localparam int MW = 32;
    localparam int TW = 3;

    localparam logic [DW-1:0] LINE_A = {4{64'hCAFE_F00D_1234_5678}};
    localparam logic [DW-1:0] LINE_B = {8{32'h0BAD_F00D}};
    localparam logic [DW-1:0] LINE_C = {8{32'h5A5A_C3C3}};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          init_start = 1'b0;
    logic          init_busy;
    logic          fill_valid = 1'b0;
    logic          fill_ready;
    logic [AW-1:0] fill_addr = '0;
    logic [DW-1:0] fill_data = '0;
    logic          ev_valid = 1'b0;
    logic          ev_ready;
    logic [AW-1:0] ev_addr = '0;
    logic          ev_rvalid;
    logic [DW-1:0] ev_rdata;
    logic          st_valid = 1'b0;
    logic          st_ready;
    logic [AW-1:0] st_addr = '0;
    logic [MW-1:0] st_wmask = '0;
    logic [DW-1:0] st_data = '0;
    logic          ld_valid = 1'b0;
    logic          ld_ready;
    logic [AW-1:0] ld_addr = '0;
    logic [TW-1:0] ld_tag = '0;
    logic          ld_rvalid;
    logic [DW-1:0] ld_rdata;
    logic [TW-1:0] ld_rtag;
    logic          sram_csb;
    logic          sram_web;
    logic [MW-1:0] sram_wmask;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_din;
    logic [DW-1:0] sram_dout = '0;

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] mem [16];

    always #5 clk = ~clk;

    // Behavioural SRAM macro: registered inputs, read data one cycle after the access.
    always @(posedge clk) begin
        if (!sram_csb) begin
            if (!sram_web) begin
                for (int b = 0; b < MW; b++) begin
                    if (sram_wmask[b]) mem[sram_addr][b*8 +: 8] <= sram_din[b*8 +: 8];
                end
            end else begin
                sram_dout <= mem[sram_addr];
            end
        end
    end

    dcache_data_array_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .init_start (init_start),
        .init_busy  (init_busy),
        .fill_valid (fill_valid),
        .fill_ready (fill_ready),
        .fill_addr  (fill_addr),
        .fill_data  (fill_data),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_addr    (ev_addr),
        .ev_rvalid  (ev_rvalid),
        .ev_rdata   (ev_rdata),
        .st_valid   (st_valid),
        .st_ready   (st_ready),
        .st_addr    (st_addr),
        .st_wmask   (st_wmask),
        .st_data    (st_data),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_addr    (ld_addr),
        .ld_tag     (ld_tag),
        .ld_rvalid  (ld_rvalid),
        .ld_rdata   (ld_rdata),
        .ld_rtag    (ld_rtag),
        .sram_csb   (sram_csb),
        .sram_web   (sram_web),
        .sram_wmask (sram_wmask),
        .sram_addr  (sram_addr),
        .sram_din   (sram_din),
        .sram_dout  (sram_dout)
    );

    task automatic idle_inputs();
        fill_valid = 1'b0;
        ev_valid   = 1'b0;
        st_valid   = 1'b0;
        ld_valid   = 1'b0;
        init_start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        fill_valid = 1'b1; ev_valid = 1'b1; st_valid = 1'b1; ld_valid = 1'b1;
        @(negedge clk); #1;
        checks++;
        if ({fill_ready, ev_ready, st_ready, ld_ready} !== 4'b0000) begin
            failures++; $display("FAIL reset_readys got %b want 0000", {fill_ready, ev_ready, st_ready, ld_ready});
        end
        checks++;
        if ({init_busy, ld_rvalid, ev_rvalid, ld_rtag} !== {1'b1, 1'b0, 1'b0, 3'd0}) begin
            failures++; $display("FAIL reset_status got %b want 100000", {init_busy, ld_rvalid, ev_rvalid, ld_rtag});
        end
        checks++;
        if ({sram_csb, sram_web, sram_wmask, sram_addr, sram_din} !== {1'b1, 1'b1, 32'h0, 4'h0, 256'h0}) begin
            failures++; $display("FAIL reset_sram got csb=%b web=%b wmask=%h addr=%h din=%h want 1 1 0 0 0",
                                 sram_csb, sram_web, sram_wmask, sram_addr, sram_din);
        end
        idle_inputs();
    endtask

    task automatic test_init_sweep();
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if ({init_busy, sram_csb, sram_web, sram_wmask, sram_addr} !== {1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 4'(i)}) begin
                failures++; $display("FAIL init_sweep[%0d] got busy=%b csb=%b web=%b wmask=%h addr=%0d want 1 0 0 ffffffff %0d",
                                     i, init_busy, sram_csb, sram_web, sram_wmask, sram_addr, i);
            end
            checks++;
            if (sram_din !== '0) begin
                failures++; $display("FAIL init_din[%0d] got %h want 0", i, sram_din);
            end
            @(negedge clk); #1;
        end
        checks++;
        if (init_busy !== 1'b0) begin
            failures++; $display("FAIL init_done got %b want 0", init_busy);
        end
        ld_valid = 1'b1; ld_addr = 4'd0; ld_tag = 3'd1;
        #1;
        checks++;
        if ({fill_ready, ev_ready, st_ready, ld_ready} !== 4'b0001) begin
            failures++; $display("FAIL first_load_ready got %b want 0001", {fill_ready, ev_ready, st_ready, ld_ready});
        end
        @(negedge clk);
        ld_valid = 1'b0;
        #1;
        checks++;
        if ({ld_rvalid, ld_rtag, ld_rdata} !== {1'b1, 3'd1, 256'h0}) begin
            failures++; $display("FAIL first_load_resp got rvalid=%b tag=%0d data=%h want 1 1 0", ld_rvalid, ld_rtag, ld_rdata);
        end
    endtask

    task automatic test_fill_raw();
        @(negedge clk);
        fill_valid = 1'b1; fill_addr = 4'd5; fill_data = LINE_A;
        #1;
        checks++;
        if ({fill_ready, ev_ready, st_ready, ld_ready} !== 4'b1000) begin
            failures++; $display("FAIL fill_ready got %b want 1000", {fill_ready, ev_ready, st_ready, ld_ready});
        end
        checks++;
        if ({sram_csb, sram_web, sram_wmask, sram_addr, sram_din} !== {1'b0, 1'b0, 32'hFFFF_FFFF, 4'd5, LINE_A}) begin
            failures++; $display("FAIL fill_sram got csb=%b web=%b wmask=%h addr=%0d din=%h",
                                 sram_csb, sram_web, sram_wmask, sram_addr, sram_din);
        end
        @(negedge clk);
        fill_valid = 1'b0;
        ld_valid = 1'b1; ld_addr = 4'd5; ld_tag = 3'd3;
        #1;
        checks++;
        if ({fill_ready, ev_ready, st_ready, ld_ready, sram_csb, ld_rvalid} !== 6'b000010) begin
            failures++; $display("FAIL raw_stall got readys=%b csb=%b rvalid=%b want 0000 1 0",
                                 {fill_ready, ev_ready, st_ready, ld_ready}, sram_csb, ld_rvalid);
        end
        @(negedge clk); #1;
        checks++;
        if ({ld_ready, sram_csb, sram_web, sram_wmask, sram_addr} !== {1'b1, 1'b0, 1'b1, 32'h0, 4'd5}) begin
            failures++; $display("FAIL raw_grant got ready=%b csb=%b web=%b wmask=%h addr=%0d want 1 0 1 0 5",
                                 ld_ready, sram_csb, sram_web, sram_wmask, sram_addr);
        end
        @(negedge clk);
        ld_valid = 1'b0;
        #1;
        checks++;
        if ({ld_rvalid, ld_rtag, ld_rdata} !== {1'b1, 3'd3, LINE_A}) begin
            failures++; $display("FAIL raw_resp got rvalid=%b tag=%0d data=%h want 1 3 line_a", ld_rvalid, ld_rtag, ld_rdata);
        end
    endtask

    task automatic test_priority();
        @(negedge clk);
        fill_valid = 1'b1; fill_addr = 4'd8;  fill_data = LINE_B;
        ev_valid   = 1'b1; ev_addr   = 4'd9;
        st_valid   = 1'b1; st_addr   = 4'd10; st_wmask = 32'h0000_FF00; st_data = LINE_C;
        ld_valid   = 1'b1; ld_addr   = 4'd11; ld_tag   = 3'd6;
        #1;
        checks++;
        if ({fill_ready, ev_ready, st_ready, ld_ready} !== 4'b1000) begin
            failures++; $display("FAIL prio_c0 got %b want 1000", {fill_ready, ev_ready, st_ready, ld_ready});
        end
        @(negedge clk);
        fill_valid = 1'b0;
        #1;
        checks++;
        if ({fill_ready, ev_ready, st_ready, ld_ready} !== 4'b0100) begin
            failures++; $display("FAIL prio_c1 got %b want 0100", {fill_ready, ev_ready, st_ready, ld_ready});
        end
        @(negedge clk);
        ev_valid = 1'b0;
        #1;
        checks++;
        if ({fill_ready, ev_ready, st_ready, ld_ready} !== 4'b0010) begin
            failures++; $display("FAIL prio_c2 got %b want 0010", {fill_ready, ev_ready, st_ready, ld_ready});
        end
        checks++;
        if ({ev_rvalid, ev_rdata} !== {1'b1, 256'h0}) begin
            failures++; $display("FAIL prio_ev_resp got rvalid=%b data=%h want 1 0", ev_rvalid, ev_rdata);
        end
        @(negedge clk);
        st_valid = 1'b0;
        #1;
        checks++;
        if ({fill_ready, ev_ready, st_ready, ld_ready} !== 4'b0001) begin
            failures++; $display("FAIL prio_c3 got %b want 0001", {fill_ready, ev_ready, st_ready, ld_ready});
        end
        @(negedge clk);
        ld_valid = 1'b0;
        #1;
        checks++;
        if ({ld_rvalid, ld_rtag, ld_rdata} !== {1'b1, 3'd6, 256'h0}) begin
            failures++; $display("FAIL prio_ld_resp got rvalid=%b tag=%0d data=%h want 1 6 0", ld_rvalid, ld_rtag, ld_rdata);
        end
    endtask

    task automatic test_store_mask();
        @(negedge clk);
        st_valid = 1'b1; st_addr = 4'd2; st_wmask = 32'h0000_000F; st_data = {8{32'hDEADBEEF}};
        #1;
        checks++;
        if ({st_ready, sram_csb, sram_web, sram_wmask, sram_addr} !== {1'b1, 1'b0, 1'b0, 32'h0000_000F, 4'd2}) begin
            failures++; $display("FAIL store_sram got ready=%b csb=%b web=%b wmask=%h addr=%0d",
                                 st_ready, sram_csb, sram_web, sram_wmask, sram_addr);
        end
        @(negedge clk);
        st_valid = 1'b0;
        ld_valid = 1'b1; ld_addr = 4'd2; ld_tag = 3'd2;
        #1;
        checks++;
        if ({fill_ready, ev_ready, st_ready, ld_ready} !== 4'b0000) begin
            failures++; $display("FAIL store_raw_stall got %b want 0000", {fill_ready, ev_ready, st_ready, ld_ready});
        end
        @(negedge clk); #1;
        checks++;
        if (ld_ready !== 1'b1) begin
            failures++; $display("FAIL store_ld_grant got %b want 1", ld_ready);
        end
        @(negedge clk);
        ld_valid = 1'b0;
        #1;
        checks++;
        if ({ld_rvalid, ld_rtag, ld_rdata} !== {1'b1, 3'd2, 224'h0, 32'hDEADBEEF}) begin
            failures++; $display("FAIL store_mask_resp got rvalid=%b tag=%0d data=%h want 1 2 deadbeef-low-only",
                                 ld_rvalid, ld_rtag, ld_rdata);
        end
    endtask

    task automatic test_ev_hazard();
        @(negedge clk);
        st_valid = 1'b1; st_addr = 4'd3; st_wmask = 32'hFFFF_FFFF; st_data = LINE_C;
        #1;
        checks++;
        if ({fill_ready, ev_ready, st_ready, ld_ready} !== 4'b0010) begin
            failures++; $display("FAIL evh_store got %b want 0010", {fill_ready, ev_ready, st_ready, ld_ready});
        end
        @(negedge clk);
        st_addr = 4'd4;
        ev_valid = 1'b1; ev_addr = 4'd3;
        #1;
        checks++;
        if ({fill_ready, ev_ready, st_ready, ld_ready} !== 4'b0010) begin
            failures++; $display("FAIL evh_blocked got %b want 0010", {fill_ready, ev_ready, st_ready, ld_ready});
        end
        @(negedge clk);
        st_valid = 1'b0;
        #1;
        checks++;
        if ({fill_ready, ev_ready, st_ready, ld_ready} !== 4'b0100) begin
            failures++; $display("FAIL evh_grant got %b want 0100", {fill_ready, ev_ready, st_ready, ld_ready});
        end
        @(negedge clk);
        ev_valid = 1'b0;
        #1;
        checks++;
        if ({ev_rvalid, ev_rdata} !== {1'b1, LINE_C}) begin
            failures++; $display("FAIL evh_resp got rvalid=%b data=%h want 1 line_c", ev_rvalid, ev_rdata);
        end
    endtask

    task automatic test_age();
        int grant_cycle;
        int expected;
        grant_cycle = -1;
`ifdef DCACHE_ARB_AGE_EN
        expected = 8;
`else
        expected = -1;
`endif
        @(negedge clk);
        st_valid = 1'b1; st_addr = 4'd6; st_wmask = 32'hFFFF_FFFF; st_data = '0;
        ld_valid = 1'b1; ld_addr = 4'd7; ld_tag = 3'd4;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (ld_ready && grant_cycle < 0) grant_cycle = c;
            @(negedge clk);
            if (grant_cycle >= 0) ld_valid = 1'b0;
        end
        idle_inputs();
        checks++;
        if (grant_cycle != expected) begin
            failures++; $display("FAIL age_grant_cycle got %0d want %0d", grant_cycle, expected);
        end
        ld_valid = 1'b1; ld_addr = 4'd7; ld_tag = 3'd4;
        #1;
        checks++;
        if (ld_ready !== 1'b1) begin
            failures++; $display("FAIL age_drain got %b want 1", ld_ready);
        end
        @(negedge clk);
        ld_valid = 1'b0;
    endtask

    task automatic test_init_restart();
        @(negedge clk);
        ld_valid = 1'b1; ld_addr = 4'd1; ld_tag = 3'd5; init_start = 1'b1;
        #1;
        checks++;
        if ({init_busy, fill_ready, ev_ready, st_ready, ld_ready} !== 5'b00001) begin
            failures++; $display("FAIL restart_grant got %b want 00001", {init_busy, fill_ready, ev_ready, st_ready, ld_ready});
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if ({init_busy, ld_rvalid, ld_rtag, sram_addr, sram_web} !== {1'b1, 1'b1, 3'd5, 4'd0, 1'b0}) begin
            failures++; $display("FAIL restart_start got busy=%b rvalid=%b tag=%0d addr=%0d web=%b want 1 1 5 0 0",
                                 init_busy, ld_rvalid, ld_rtag, sram_addr, sram_web);
        end
        repeat (9) @(negedge clk);
        #1;
        checks++;
        if (sram_addr !== 4'd9) begin
            failures++; $display("FAIL restart_cnt9 got %0d want 9", sram_addr);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({init_busy, sram_csb, sram_addr} !== {1'b1, 1'b1, 4'd0}) begin
            failures++; $display("FAIL midinit_rst got busy=%b csb=%b addr=%0d want 1 1 0", init_busy, sram_csb, sram_addr);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({sram_csb, sram_web, sram_addr} !== {1'b0, 1'b0, 4'd0}) begin
            failures++; $display("FAIL midinit_restart got csb=%b web=%b addr=%0d want 0 0 0", sram_csb, sram_web, sram_addr);
        end
        repeat (16) @(negedge clk);
        #1;
        checks++;
        if (init_busy !== 1'b0) begin
            failures++; $display("FAIL restart_done got %b want 0", init_busy);
        end
        ld_valid = 1'b1; ld_addr = 4'd1; ld_tag = 3'd7;
        #1;
        checks++;
        if (ld_ready !== 1'b1) begin
            failures++; $display("FAIL pre_rst_grant got %b want 1", ld_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        ld_valid = 1'b0;
        @(negedge clk); #1;
        checks++;
        if ({ld_rvalid, ld_rtag} !== {1'b0, 3'd0}) begin
            failures++; $display("FAIL rst_kills_resp got rvalid=%b tag=%0d want 0 0", ld_rvalid, ld_rtag);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (17) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_init_sweep();
        test_fill_raw();
        test_priority();
        test_store_mask();
        test_ev_hazard();
        test_age();
        test_init_restart();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
